// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the MIPS fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam int          IM_WORDS_DEF = 4096;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef logic [4:0] exc_code_t;

    localparam exc_code_t EXC_NONE = 5'd0;
    localparam exc_code_t EXC_ADEL = 5'd4;

    // True when pc is misaligned or outside [base, limit); limit is 33 bits
    // so an IM that ends exactly at 2^32 still compares correctly.
    function automatic logic fetch_error(input logic [31:0] pc,
                                         input logic [31:0] base,
                                         input logic [32:0] limit);
        return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, its PC, link value, fetch exception
// code and bubble flag. Priority is clear > stall > load.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        stall,
    input  logic [31:0] ir_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc8_in,
    input  exc_code_t   exc_in,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic [31:0] pc8,
    output exc_code_t   exc,
    output logic        bubble
);

    // Bubble on clear (PC still tracks F so D_PC stays meaningful), hold on stall, else load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir     <= NOP;
            pc     <= PC_RESET;
            pc8    <= PC_RESET + 32'd8;
            exc    <= EXC_NONE;
            bubble <= 1'b1;
        end else if (clear) begin
            ir     <= NOP;
            pc     <= pc_in;
            pc8    <= pc8_in;
            exc    <= EXC_NONE;
            bubble <= 1'b1;
        end else if (!stall) begin
            ir     <= ir_in;
            pc     <= pc_in;
            pc8    <= pc8_in;
            exc    <= exc_in;
            bubble <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// F stage: PC register, next-PC selection, fetch address check and the
// IF/ID register feeding the decoder.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        clear,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] D_IR,
    output logic [31:0] D_PC,
    output logic [31:0] D_PC8,
    output logic [4:0]  D_exc,
    output logic        D_bubble
);

    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic        fetch_err;
    logic [31:0] ir_next;
    exc_code_t   exc_next;

    assign pc_plus4  = pc_q + 32'd4;
    assign pc_plus8  = pc_q + 32'd8;
    assign fetch_err = fetch_error(pc_q, IM_BASE, IM_END);
    assign ir_next   = fetch_err ? NOP : im_rdata;
    assign exc_next  = fetch_err ? EXC_ADEL : EXC_NONE;

    assign F_PC    = pc_q;
    assign im_addr = pc_q;

    // PC: stall freezes it (a redirect seen during stall is re-asserted by D later),
    // otherwise take the redirect target or fall through to PC+4.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc_q <= PC_RESET;
        else if (!stall)
            pc_q <= redirect ? redirect_pc : pc_plus4;
    end

    if_id_reg #(
        .PC_RESET(PC_RESET)
    ) u_if_id (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .stall  (stall),
        .ir_in  (ir_next),
        .pc_in  (pc_q),
        .pc8_in (pc_plus8),
        .exc_in (exc_next),
        .ir     (D_IR),
        .pc     (D_PC),
        .pc8    (D_PC8),
        .exc    (D_exc),
        .bubble (D_bubble)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes hand-computed expected
// state, a monitor pops and compares at each falling edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        clear;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] F_PC;
    logic [31:0] D_IR;
    logic [31:0] D_PC;
    logic [31:0] D_PC8;
    logic [4:0]  D_exc;
    logic        D_bubble;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [31:0] fpc;
        logic [31:0] dir;
        logic [31:0] dpc;
        logic [4:0]  exc;
        logic        bub;
    } exp_t;

    exp_t sb[$];
    event sample_ev;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .clear       (clear),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_addr     (im_addr),
        .im_rdata    (im_rdata),
        .F_PC        (F_PC),
        .D_IR        (D_IR),
        .D_PC        (D_PC),
        .D_PC8       (D_PC8),
        .D_exc       (D_exc),
        .D_bubble    (D_bubble)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string field,
                       input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s %s got %h want %h", name, field, got, want);
        end
    endtask

    // Monitor: compare DUT state against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "F_PC",     F_PC,            e.fpc);
                chk(e.name, "im_addr",  im_addr,         e.fpc);
                chk(e.name, "D_IR",     D_IR,            e.dir);
                chk(e.name, "D_PC",     D_PC,            e.dpc);
                chk(e.name, "D_PC8",    D_PC8,           e.dpc + 32'd8);
                chk(e.name, "D_exc",    {27'd0, D_exc},  {27'd0, e.exc});
                chk(e.name, "D_bubble", {31'd0, D_bubble}, {31'd0, e.bub});
            end
        end
    end

    task automatic push(input string name, input logic [31:0] fpc, input logic [31:0] dir,
                        input logic [31:0] dpc, input logic [4:0] exc, input logic bub);
        exp_t e;
        e.name = name; e.fpc = fpc; e.dir = dir; e.dpc = dpc; e.exc = exc; e.bub = bub;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs and queue the state expected after the next rising edge.
    task automatic step(input string name, input logic st, input logic cl, input logic rd,
                        input logic [31:0] rpc, input logic [31:0] rdata,
                        input logic [31:0] efpc, input logic [31:0] edir,
                        input logic [31:0] edpc, input logic [4:0] eexc, input logic ebub);
        stall = st; clear = cl; redirect = rd; redirect_pc = rpc; im_rdata = rdata;
        push(name, efpc, edir, edpc, eexc, ebub);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        n_cmp++; n_bad++;
        $display("FAIL watchdog got timeout want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        reset = 1'b1; stall = 1'b0; clear = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; im_rdata = 32'h3401_0001;
        push("reset", 32'h3000, 32'h0, 32'h3000, 5'd0, 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // free run
        step("run0", 0,0,0, 32'h0, 32'h3401_0001, 32'h3004, 32'h3401_0001, 32'h3000, 5'd0, 1'b0);
        step("run1", 0,0,0, 32'h0, 32'h3401_0001, 32'h3008, 32'h3401_0001, 32'h3004, 5'd0, 1'b0);
        step("run2", 0,0,0, 32'h0, 32'h3401_0001, 32'h300C, 32'h3401_0001, 32'h3008, 5'd0, 1'b0);
        step("run3", 0,0,0, 32'h0, 32'h3401_0001, 32'h3010, 32'h3401_0001, 32'h300C, 5'd0, 1'b0);

        // stall holds PC and IF/ID
        step("stall0", 1,0,0, 32'h0, 32'hDEAD_BEEF, 32'h3010, 32'h3401_0001, 32'h300C, 5'd0, 1'b0);
        step("stall1", 1,0,0, 32'h0, 32'hDEAD_BEEF, 32'h3010, 32'h3401_0001, 32'h300C, 5'd0, 1'b0);
        step("unstall", 0,0,0, 32'h0, 32'h1111_1111, 32'h3014, 32'h1111_1111, 32'h3010, 5'd0, 1'b0);
        step("run4", 0,0,0, 32'h0, 32'h2222_2222, 32'h3018, 32'h2222_2222, 32'h3014, 5'd0, 1'b0);
        step("run5", 0,0,0, 32'h0, 32'h3333_3333, 32'h301C, 32'h3333_3333, 32'h3018, 5'd0, 1'b0);
        step("run6", 0,0,0, 32'h0, 32'h4444_4444, 32'h3020, 32'h4444_4444, 32'h301C, 5'd0, 1'b0);

        // redirect with delay slot
        step("redir", 0,0,1, 32'h3100, 32'h5555_5555, 32'h3100, 32'h5555_5555, 32'h3020, 5'd0, 1'b0);
        step("tgt", 0,0,0, 32'h0, 32'h6666_6666, 32'h3104, 32'h6666_6666, 32'h3100, 5'd0, 1'b0);

        // stall beats redirect
        step("st_redir", 1,0,1, 32'h3200, 32'h7777_7777, 32'h3104, 32'h6666_6666, 32'h3100, 5'd0, 1'b0);
        step("redir2", 0,0,1, 32'h3200, 32'h8888_8888, 32'h3200, 32'h8888_8888, 32'h3104, 5'd0, 1'b0);

        // clear beats stall, PC holds
        step("clr_st", 1,1,0, 32'h0, 32'h9999_9999, 32'h3200, 32'h0, 32'h3200, 5'd0, 1'b1);
        step("after_clr", 0,0,0, 32'h0, 32'hAAAA_AAAA, 32'h3204, 32'hAAAA_AAAA, 32'h3200, 5'd0, 1'b0);

        // misaligned and below-base fetches
        step("redir_mis", 0,0,1, 32'h3002, 32'hBBBB_BBBB, 32'h3002, 32'hBBBB_BBBB, 32'h3204, 5'd0, 1'b0);
        step("mis_err", 0,0,0, 32'h0, 32'hCCCC_CCCC, 32'h3006, 32'h0, 32'h3002, 5'd4, 1'b0);
        step("redir_low", 0,0,1, 32'h2FFC, 32'hCCCC_CCCC, 32'h2FFC, 32'h0, 32'h3006, 5'd4, 1'b0);
        step("low_err", 0,0,0, 32'h0, 32'hCCCC_CCCC, 32'h3000, 32'h0, 32'h2FFC, 5'd4, 1'b0);
        step("base_ok", 0,0,0, 32'h0, 32'hDDDD_DDDD, 32'h3004, 32'hDDDD_DDDD, 32'h3000, 5'd0, 1'b0);

        // upper IM boundary: 6FFC legal, 7000 out of range
        step("redir_top", 0,0,1, 32'h6FFC, 32'hEEEE_EEEE, 32'h6FFC, 32'hEEEE_EEEE, 32'h3004, 5'd0, 1'b0);
        step("top_ok", 0,0,0, 32'h0, 32'h1234_5678, 32'h7000, 32'h1234_5678, 32'h6FFC, 5'd0, 1'b0);
        step("top_err", 0,0,0, 32'h0, 32'h8765_4321, 32'h7004, 32'h0, 32'h7000, 5'd4, 1'b0);

        // async reset mid-cycle, with stall and redirect pending
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h5000;
        #2;
        reset = 1'b1;
        #1;
        push("async_rst", 32'h3000, 32'h0, 32'h3000, 5'd0, 1'b1);
        ->sample_ev;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        step("post_rst", 0,0,0, 32'h0, 32'h0F0F_0F0F, 32'h3004, 32'h0F0F_0F0F, 32'h3000, 5'd0, 1'b0);

        #1;
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
